// File: rtl/rr_arb4_ctrl_pkg.sv
// rtl/rr_arb4_ctrl_pkg.sv - shared types, constants and rotating-priority pick for rr_arb4_ctrl
package rr_arb4_ctrl_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set request bit scanning ptr, ptr+1, ... with wrap-around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arb4_ctrl_gnt_decoder.sv
// rtl/rr_arb4_ctrl_gnt_decoder.sv - 2-to-4 one-hot decoder with enable
import rr_arb4_ctrl_pkg::*;

module gnt_decoder (
  input  logic               i_en,
  input  logic [IDX_W-1:0]   i_id,
  output logic [NUM_REQ-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_id] = 1'b1;
  end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// rtl/rr_arb4_ctrl.sv - 4-way round-robin arbiter with hold-time pre-emption; ARB_LOCK_EN adds the lock input
import rr_arb4_ctrl_pkg::*;

module rr_arb4_ctrl #(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
`ifdef ARB_LOCK_EN
  input  logic               lock,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               gnt_valid
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_gnt_id;
  logic [7:0]          r_hold_cnt;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_gnt_valid;
  logic                w_lock;
  logic                w_others;
  logic                w_preempt;
  logic                w_release;

`ifdef ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // w_gnt is zero outside GRANT, so only the owner's bit is masked.
  assign w_others  = |(req & ~w_gnt);
  assign w_preempt = (r_hold_cnt == MAX_HOLD_C) && w_others && !w_lock;
  assign w_release = !req[r_gnt_id] || w_preempt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req)     w_state_nxt = GRANT;
      GRANT:   if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_valid = (r_state == GRANT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_gnt_id   <= '0;
      r_hold_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (|req) begin
        r_gnt_id   <= rr_pick(req, r_ptr);
        r_hold_cnt <= 8'd1;
      end
    end else if (w_release) begin
      r_ptr      <= r_gnt_id + 1'b1;
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != MAX_HOLD_C) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  gnt_decoder u_gnt_decoder (
    .i_en     (w_gnt_valid),
    .i_id     (r_gnt_id),
    .o_onehot (w_gnt)
  );

  assign gnt       = w_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = w_gnt_valid;

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// tb/tb_rr_arb4_ctrl.sv - self-checking bench for rr_arb4_ctrl: vector table, corner sequences, random vs model
module tb_rr_arb4_ctrl;

  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock_in;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  always #5 clk = ~clk;

  rr_arb4_ctrl #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ARB_LOCK_EN
    .lock      (lock_in),
`endif
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  int errors = 0;
  int checks = 0;

  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge(input logic r, input logic [3:0] q, input logic lk);
    logic lk_eff;
    int   others;
`ifdef ARB_LOCK_EN
    lk_eff = lk;
`else
    lk_eff = 1'b0;
    if (lk) lk_eff = 1'b0;
`endif
    if (r) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && q[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_cnt   = 1;
        end
      end
    end else begin
      others = int'(q) & ~(1 << m_owner);
      if (!q[m_owner] || (m_cnt == MH && others != 0 && !lk_eff)) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_cnt   = 0;
      end else if (m_cnt < MH) begin
        m_cnt++;
      end
    end
  endfunction

  function automatic logic [3:0] model_gnt();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  task automatic step(input logic r, input logic [3:0] q, input logic lk);
    rst = r; req = q; lock_in = lk;
    @(posedge clk);
    model_edge(r, q, lk);
    #1;
  endtask

  initial begin
    logic [3:0] q;
    logic [3:0] exp;
    logic [3:0] prev_gnt;
    logic       r;
    int         waitc[4];

    rst = 1'b1; req = 4'b0000; lock_in = 1'b0;

    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
    tbl[2]  = '{1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1};
    tbl[4]  = '{1'b0, 4'b1100, 4'b0000, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[8]  = '{1'b1, 4'b1001, 4'b0000, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1};
    tbl[10] = '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[13] = '{1'b0, 4'b0110, 4'b0000, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1};
    tbl[15] = '{1'b0, 4'b1011, 4'b0010, 2'd1, 1'b1};
    tbl[16] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, 1'b0);
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("vec%0d_valid", i), 32'(gnt_valid), 32'(tbl[i].valid));
      if (tbl[i].valid || tbl[i].rst)
        check($sformatf("vec%0d_id", i), 32'(gnt_id), 32'(tbl[i].id));
    end

    // Lone requester keeps its grant past saturation.
    step(1'b1, 4'b0000, 1'b0);
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 4'b0100, 1'b0);
      check("lone_hold", 32'(gnt), 32'(4'b0100));
    end

    // Two contenders alternate every MH cycles with one idle gap.
    step(1'b1, 4'b0000, 1'b0);
    for (int c = 0; c < 2 * MH + 3; c++) begin
      step(1'b0, 4'b0101, 1'b0);
      if (c < MH)              exp = 4'b0001;
      else if (c == MH)        exp = 4'b0000;
      else if (c < 2 * MH + 1) exp = 4'b0100;
      else if (c == 2 * MH + 1) exp = 4'b0000;
      else                     exp = 4'b0001;
      check($sformatf("preempt_c%0d", c), 32'(gnt), 32'(exp));
    end

`ifdef ARB_LOCK_EN
    step(1'b1, 4'b0000, 1'b0);
    for (int c = 0; c < MH + 4; c++) begin
      step(1'b0, 4'b0011, 1'b1);
      check("lock_hold", 32'(gnt), 32'(4'b0001));
    end
    step(1'b0, 4'b0011, 1'b0);
    check("lock_drop_idle", 32'(gnt), 32'(4'b0000));
    step(1'b0, 4'b0011, 1'b0);
    check("lock_drop_next", 32'(gnt), 32'(4'b0010));
`endif

    step(1'b1, 4'b0000, 1'b0);
    q = 4'b0000;
    prev_gnt = 4'b0000;
    foreach (waitc[i]) waitc[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 999) == 0);
      step(r, q, 1'b0);
      check("rand_gnt", 32'(gnt), 32'(model_gnt()));
      check("rand_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      if (m_owner >= 0) check("rand_id", 32'(gnt_id), 32'(m_owner));
      check("rand_onehot", 32'($countones(gnt) <= 1), 32'd1);
      if (gnt_valid) check("rand_decode", 32'(gnt), 32'(4'b0001 << gnt_id));
      if (prev_gnt != 4'b0000 && gnt != 4'b0000)
        check("rand_turnaround", 32'(gnt), 32'(prev_gnt));
      for (int i = 0; i < 4; i++) begin
        if (q[i] && !gnt[i] && !r) waitc[i]++;
        else                       waitc[i] = 0;
        if (waitc[i] > 3 * (MH + 1))
          check($sformatf("rand_wait%0d", i), 32'(waitc[i]), 32'(3 * (MH + 1)));
      end
      prev_gnt = gnt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb4_ctrl.md
RR_ARB4_CTRL -- requirements
Module: rr_arb4_ctrl

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning the number of granted cycles after which the owner is pre-empted if another requester waits; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 4 bits: per-requester request levels, with bit i belonging to requester i.
REQ-005 SHALL have port lock, input, 1 bit: owner asks not to be pre-empted; present only when ARB_LOCK_EN is defined.
REQ-006 SHALL have port gnt, output, 4 bits: one-hot grant, all zero when no owner.
REQ-007 SHALL have port gnt_id, output, 2 bits: binary index of the owner, valid only while gnt_valid is 1.
REQ-008 SHALL have port gnt_valid, output, 1 bit: high exactly while any gnt bit is high.

Function
REQ-009 SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-010 IDLE->GRANT: at an edge with req!=0, SHALL select the first set req bit searching ptr, ptr+1, ... modulo 4; gnt, gnt_id and gnt_valid are registered and visible the cycle after req is sampled (1-cycle latency).
REQ-011 In GRANT SHALL count owned cycles in hold_cnt, with 1 on the first granted cycle, saturating at MAX_HOLD.
REQ-012 GRANT->IDLE (release): at an edge where req[gnt_id]==0, SHALL clear gnt and gnt_valid, then set ptr=gnt_id+1 mod 4.
REQ-013 GRANT->IDLE (pre-empt): at an edge where hold_cnt==MAX_HOLD and any other req bit is 1, SHALL release even if the owner still requests, and SHALL set ptr=gnt_id+1 mod 4.
REQ-014 If hold_cnt==MAX_HOLD and no other req bit is set, SHALL keep the grant and hold hold_cnt at MAX_HOLD.
REQ-015 Every release SHALL be followed by at least one IDLE cycle with gnt==0 (turnaround); back-to-back grants to different owners are never adjacent.
REQ-016 gnt SHALL never have more than one bit set, and gnt SHALL equal decode(gnt_id) whenever gnt_valid==1.
REQ-017 Request bits of non-owners changing during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-018 When release and pre-empt conditions are both true at the same edge, SHALL release, with the same next state and ptr.

Reset
REQ-019 With rst==1 at an edge, SHALL set the state to IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, hold_cnt=0 and ptr=0; this overrides any other event, including mid-grant.
REQ-020 The first arbitration after reset SHALL give requester 0 top priority.

Configuration
REQ-021 With macro ARB_LOCK_EN defined, the lock port SHALL exist, and lock==1 at an edge SHALL suppress REQ-013 pre-emption (voluntary release still applies).
REQ-022 Without ARB_LOCK_EN, the lock port SHALL be absent and pre-emption SHALL always apply.

Structure
REQ-023 A shared package SHALL hold the state enum (IDLE, GRANT), the requester count constant 4 and the index width constant 2.
REQ-024 The one-hot gnt SHALL be produced from gnt_id by one sub-module, gnt_decoder, a 2-to-4 decoder with enable driven by gnt_valid.

Verification
REQ-025 After reset, req=4'b1111 -> next cycle gnt=0001, gnt_id=0; drop req[0] -> gnt=0000 one cycle, then gnt=0010.
REQ-026 req=4'b0100 held only -> gnt=0100 indefinitely, hold_cnt saturates at 8, no release.
REQ-027 req=4'b0101 held, MAX_HOLD=8, no lock -> gnt=0001 for 8 cycles, 1 idle cycle, then gnt=0100 for 8 cycles, 1 idle cycle, then gnt=0001.
REQ-028 ARB_LOCK_EN, req=4'b0011, lock=1 -> owner 0 keeps gnt=0001 beyond 8 cycles; lock=0 with hold_cnt==8 -> release, next gnt=0010.
REQ-029 rst=1 asserted mid-grant (gnt=1000) -> next cycle gnt=0000, gnt_valid=0; with req=4'b1001 still held after rst drops -> gnt=0001 (ptr reset to 0).
REQ-030 Random req, 10k cycles -> assertions: gnt one-hot or zero, gnt==decode(gnt_id), turnaround cycle after every release, no requester waits more than 3*(MAX_HOLD+1) cycles.
